// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the multiplexed BCD display.
// Holds the active-low segment patterns ([0]=a .. [6]=g, [7]=dp), the
// digit-index encoding used by the scanner, and a helper that turns an
// index into its active-low digit enable.
package bcd_disp_pkg;

  typedef enum logic [2:0] {
    DIG_ONES = 3'd0,
    DIG_TENS = 3'd1,
    DIG_HUND = 3'd2,
    DIG_THOU = 3'd3,
    DIG_SIGN = 3'd4
  } dig_idx_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_E     = 8'h86;  // a,d,e,f,g
  localparam logic [7:0] SEG_MINUS = 8'hBF;  // g only
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [4:0] DIG_ALL_OFF = 5'h1F;

  function automatic logic [4:0] dig_enable(input dig_idx_t idx);
    logic [4:0] one_hot;
    one_hot = 5'b00001 << idx;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to 7-segment lookup (active-low, dp off).
// Ports: nib - BCD nibble; seg - segment pattern, "E" for nibbles above 9.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_E;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed driver for a signed 4-digit BCD display plus sign digit.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   bcd         - [16] sign, [15:0] four BCD digits (thousands..ones)
//   bcd_vld     - single-cycle strobe qualifying bcd
//   seg         - active-low segments, registered
//   dig_sel     - active-low digit enables [0] ones .. [4] sign, registered
//   frame_done  - pulse on the last cycle of each frame
// Incoming values are buffered in a shadow register and only move to the
// displayed value at the frame boundary, so a frame never mixes two values.
module bcd_seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GUARD    = 2,
  parameter int unsigned LZ_BLANK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] bcd,
  input  logic        bcd_vld,
  output logic [7:0]  seg,
  output logic [4:0]  dig_sel,
  output logic        frame_done
);

  localparam int unsigned    CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  CNT_PRE   = CW'(SCAN_DIV - 2);
  localparam logic [CW-1:0]  CNT_GUARD = CW'(GUARD);
  localparam logic           LZ        = (LZ_BLANK != 0);

  logic [CW-1:0] cnt, cnt_nxt;
  dig_idx_t      idx, idx_nxt;
  logic          slot_end, boundary;

  logic [16:0]   shadow, disp;
  logic          pending;

  logic [3:0]    th, hu, te, on;
  logic          sign, mag_zero;
  logic          blank_th, blank_hu, blank_te, slot_blank;
  logic [3:0]    sel_nib;
  logic [7:0]    dec_seg;
  logic [7:0]    seg_nxt;
  logic [4:0]    dig_nxt;

  // Scan position: divider counter and digit index
  always_comb begin
    slot_end = (cnt == CNT_LAST);
    boundary = slot_end && (idx == DIG_SIGN);
    cnt_nxt  = slot_end ? '0 : cnt + 1'b1;
    idx_nxt  = idx;
    if (slot_end) begin
      case (idx)
        DIG_ONES: idx_nxt = DIG_TENS;
        DIG_TENS: idx_nxt = DIG_HUND;
        DIG_HUND: idx_nxt = DIG_THOU;
        DIG_THOU: idx_nxt = DIG_SIGN;
        default:  idx_nxt = DIG_ONES;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= DIG_ONES;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
    end
  end

  // Capture: a strobe on the boundary cycle bypasses the shadow so the
  // value appears in the very next frame and nothing is left pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else begin
      if (bcd_vld)
        shadow <= bcd;
      if (boundary) begin
        if (bcd_vld)
          disp <= bcd;
        else if (pending)
          disp <= shadow;
        pending <= 1'b0;
      end else if (bcd_vld) begin
        pending <= 1'b1;
      end
    end
  end

  // Leading-zero blanking; a non-zero nibble (including >9) stops it.
  always_comb begin
    th       = disp[15:12];
    hu       = disp[11:8];
    te       = disp[7:4];
    on       = disp[3:0];
    sign     = disp[16];
    mag_zero = (disp[15:0] == '0);
    blank_th = LZ && (th == 4'd0);
    blank_hu = blank_th && (hu == 4'd0);
    blank_te = blank_hu && (te == 4'd0);

    sel_nib    = on;
    slot_blank = 1'b0;
    case (idx)
      DIG_ONES: begin sel_nib = on; slot_blank = 1'b0;     end
      DIG_TENS: begin sel_nib = te; slot_blank = blank_te; end
      DIG_HUND: begin sel_nib = hu; slot_blank = blank_hu; end
      DIG_THOU: begin sel_nib = th; slot_blank = blank_th; end
      default:  begin sel_nib = on; slot_blank = !(sign && !mag_zero); end
    endcase
  end

  seg7_decode u_dec (
    .nib (sel_nib),
    .seg (dec_seg)
  );

  // A blanked position keeps its digit enable off as well.
  always_comb begin
    seg_nxt = SEG_BLANK;
    dig_nxt = DIG_ALL_OFF;
    if (cnt >= CNT_GUARD && !slot_blank) begin
      seg_nxt = (idx == DIG_SIGN) ? SEG_MINUS : dec_seg;
      dig_nxt = dig_enable(idx);
    end
  end

  // frame_done is registered from the cycle before the boundary so it
  // lines up with the boundary state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= SEG_BLANK;
      dig_sel    <= DIG_ALL_OFF;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_nxt;
      dig_sel    <= dig_nxt;
      frame_done <= (idx == DIG_SIGN) && (cnt == CNT_PRE);
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan with SCAN_DIV=8, GUARD=2, LZ_BLANK=1.
// Each frame is 40 cycles; output sample m (0..39) reflects scan position
// m because seg/dig_sel lag the scan state by one cycle.
module tb_bcd_seg_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] bcd = '0;
  logic        bcd_vld = 1'b0;
  logic [7:0]  seg;
  logic [4:0]  dig_sel;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_seg [5];
  logic [4:0] dig_tab [5];

  always #5 clk = ~clk;

  bcd_seg_scan #(
    .SCAN_DIV (8),
    .GUARD    (2),
    .LZ_BLANK (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd        (bcd),
    .bcd_vld    (bcd_vld),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Runs n_m output samples of a frame against exp_seg; optionally pulses
  // bcd_vld after sample v1_m / v2_m so it is captured on the next edge.
  task automatic frame(input string name, input int n_m,
                       input int v1_m, input logic [16:0] b1,
                       input int v2_m, input logic [16:0] b2);
    logic [7:0] es;
    logic [4:0] ed;
    int slot, pos;
    for (int m = 0; m < n_m; m++) begin
      @(posedge clk); #1;
      slot = m / 8;
      pos  = m % 8;
      if (pos < 2 || exp_seg[slot] == 8'hFF) begin
        es = 8'hFF;
        ed = 5'h1F;
      end else begin
        es = exp_seg[slot];
        ed = dig_tab[slot];
      end
      chk($sformatf("%s seg m%0d", name, m), seg, es);
      chk($sformatf("%s dig m%0d", name, m), {3'b0, dig_sel}, {3'b0, ed});
      chk($sformatf("%s fdone m%0d", name, m), {7'b0, frame_done}, {7'b0, (m == 38)});
      bcd_vld = 1'b0;
      if (m == v1_m) begin bcd = b1; bcd_vld = 1'b1; end
      if (m == v2_m) begin bcd = b2; bcd_vld = 1'b1; end
    end
  endtask

  task automatic chk_reset(input string name);
    @(posedge clk); #1;
    chk({name, " seg"}, seg, 8'hFF);
    chk({name, " dig"}, {3'b0, dig_sel}, 8'h1F);
    chk({name, " fdone"}, {7'b0, frame_done}, 8'h00);
  endtask

  initial begin
    dig_tab = '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h0F};

    chk_reset("rst0");
    chk_reset("rst1");
    chk_reset("rst2");
    rst = 1'b0;

    // Default "0"; 1234 arrives mid-frame and must not show yet
    exp_seg = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    frame("f1", 40, 10, 17'h0_1234, -1, '0);

    // 1234, sign blank; load -56 mid-frame
    exp_seg = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hFF};
    frame("f2", 40, 5, 17'h1_0056, -1, '0);

    // -56: minus in sign slot; two strobes, last (9) wins
    exp_seg = '{8'h82, 8'h92, 8'hFF, 8'hFF, 8'hBF};
    frame("f3", 40, 3, 17'h0_0001, 20, 17'h0_0009);

    // 9 only; strobe 0A00 on the boundary cycle
    exp_seg = '{8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    frame("f4", 40, 38, 17'h0_0A00, -1, '0);

    // 0A00 shown immediately: E in hundreds stops blanking of tens
    exp_seg = '{8'hC0, 8'hC0, 8'h86, 8'hFF, 8'hFF};
    frame("f5", 40, -1, '0, -1, '0);

    // Make 0777 pending, then reset inside the tens slot
    frame("f6", 12, 3, 17'h0_0777, -1, '0);
    rst = 1'b1;
    chk_reset("midrst0");
    chk_reset("midrst1");
    rst = 1'b0;

    // Restart at ones with cleared display; pending 0777 never appears
    exp_seg = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    frame("f7", 40, -1, '0, -1, '0);
    frame("f8", 40, -1, '0, -1, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
